// File: rtl/usb_ls_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_ls_rx : low-speed USB receiver (sync detect, NRZI decode, unstuffing).
//             Define USB_RX_PID_CHECK_EN to validate the first byte as a PID.
// Rev 1.0
// ---------------------------------------------------------------------------
module usb_ls_rx #(
  parameter int CLKS_PER_BIT = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       usb_dp,
  input  logic       usb_dn,
  input  logic       rx_enable,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_error
);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] c_half_bit = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] c_reload   = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {LS_J = 2'd0, LS_K = 2'd1, LS_SE0 = 2'd2} line_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SYNC = 2'd1, ST_DATA = 2'd2, ST_EOP = 2'd3} state_t;

  logic [1:0]    r_dp_sync, r_dn_sync;
  line_t         w_line, r_line_prev, r_last_jk;
  logic [CW-1:0] r_phase;
  logic          w_sample, w_se0, w_bit, w_pid_bad;

  state_t        r_state, n_state;
  logic [2:0]    r_zeros, n_zeros, r_ones, n_ones, r_bits, n_bits;
  logic [6:0]    r_shift, n_shift;
  logic [7:0]    n_data;
  logic          r_pending, n_pending, r_good, n_good, r_se0_seen, n_se0_seen;
  logic          n_valid, n_active, n_eop, n_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_sync <= 2'b00;
      r_dn_sync <= 2'b11;
    end else begin
      r_dp_sync <= {r_dp_sync[0], usb_dp};
      r_dn_sync <= {r_dn_sync[0], usb_dn};
    end
  end

  always_comb begin
    w_line = LS_SE0;
    if (r_dp_sync[1] && !r_dn_sync[1])      w_line = LS_K;
    else if (!r_dp_sync[1] && r_dn_sync[1]) w_line = LS_J;
  end

  // Phase counter re-centres on every line change so samples land mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_prev <= LS_J;
      r_phase     <= '0;
      r_last_jk   <= LS_J;
    end else begin
      r_line_prev <= w_line;
      if (w_line != r_line_prev) r_phase <= c_half_bit;
      else if (r_phase == '0)    r_phase <= c_reload;
      else                       r_phase <= r_phase - CW'(1);
      if (w_sample && !w_se0)    r_last_jk <= w_line;
    end
  end

  assign w_sample = (w_line == r_line_prev) && (r_phase == '0);
  assign w_se0    = (w_line == LS_SE0);
  assign w_bit    = (w_line == r_last_jk);

`ifdef USB_RX_PID_CHECK_EN
  logic r_first, n_first;
  always_comb begin
    n_first = r_first;
    if (r_state == ST_SYNC && n_state == ST_DATA) n_first = 1'b1;
    else if (r_pending)                           n_first = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_first <= 1'b0;
    else        r_first <= n_first;
  end
  assign w_pid_bad = r_first && (rx_data[7:4] != ~rx_data[3:0]);
`else
  assign w_pid_bad = 1'b0;
`endif

  always_comb begin
    n_state    = r_state;
    n_zeros    = r_zeros;
    n_ones     = r_ones;
    n_bits     = r_bits;
    n_shift    = r_shift;
    n_data     = rx_data;
    n_pending  = 1'b0;
    n_good     = r_good;
    n_se0_seen = r_se0_seen;
    n_valid    = 1'b0;
    n_active   = rx_active;
    n_eop      = 1'b0;
    n_error    = 1'b0;
    if (!rx_enable) begin
      n_state  = ST_IDLE;
      n_active = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_sample && w_line == LS_K) begin
          n_state = ST_SYNC;
          n_zeros = 3'd1;
        end
        ST_SYNC: if (w_sample) begin
          if (w_se0) n_state = ST_IDLE;
          else if (!w_bit) begin
            if (r_zeros != 3'd7) n_zeros = r_zeros + 3'd1;
          end else if (r_zeros >= 3'd5) begin
            n_state    = ST_DATA;
            n_active   = 1'b1;
            n_ones     = 3'd0;
            n_bits     = 3'd0;
            n_good     = 1'b0;
            n_se0_seen = 1'b0;
          end else n_state = ST_IDLE;
        end
        ST_DATA: begin
          if (r_pending) begin
            if (w_pid_bad) begin
              n_state  = ST_EOP;
              n_active = 1'b0;
              n_error  = 1'b1;
            end else n_valid = 1'b1;
          end
          if (w_sample) begin
            if (w_se0) begin
              n_state    = ST_EOP;
              n_se0_seen = 1'b1;
              if (r_bits == 3'd0) n_good = 1'b1;
              else begin
                n_error  = 1'b1;
                n_active = 1'b0;
              end
            end else if (r_ones == 3'd6) begin
              // Bit following six ones must be a stuffed zero; a one is a violation.
              n_ones = 3'd0;
              if (w_bit) begin
                n_state  = ST_EOP;
                n_error  = 1'b1;
                n_active = 1'b0;
              end
            end else begin
              n_ones  = w_bit ? r_ones + 3'd1 : 3'd0;
              n_shift = {w_bit, r_shift[6:1]};
              n_bits  = r_bits + 3'd1;
              if (r_bits == 3'd7) begin
                n_data    = {w_bit, r_shift};
                n_pending = 1'b1;
              end
            end
          end
        end
        ST_EOP: if (w_sample) begin
          if (w_se0) n_se0_seen = 1'b1;
          else if (w_line == LS_J && r_se0_seen) begin
            n_state  = ST_IDLE;
            n_eop    = r_good;
            n_active = 1'b0;
            n_good   = 1'b0;
          end
        end
        default: n_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_zeros    <= 3'd0;
      r_ones     <= 3'd0;
      r_bits     <= 3'd0;
      r_shift    <= 7'd0;
      r_pending  <= 1'b0;
      r_good     <= 1'b0;
      r_se0_seen <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_active  <= 1'b0;
      rx_eop     <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      r_state    <= n_state;
      r_zeros    <= n_zeros;
      r_ones     <= n_ones;
      r_bits     <= n_bits;
      r_shift    <= n_shift;
      r_pending  <= n_pending;
      r_good     <= n_good;
      r_se0_seen <= n_se0_seen;
      rx_data    <= n_data;
      rx_valid   <= n_valid;
      rx_active  <= n_active;
      rx_eop     <= n_eop;
      rx_error   <= n_error;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_usb_ls_rx.sv
`default_nettype none
// tb_usb_ls_rx : packet-level stimulus, expected bytes/strobes derived from the packet recipe.
module tb_usb_ls_rx;
  localparam int CLKS_PER_BIT = 18;
  localparam logic [1:0] W_J = 2'd0, W_K = 2'd1, W_SE0 = 2'd2;
  localparam int K_GOOD = 0, K_ALIGN = 1, K_STUFF = 2, K_ABORT = 3, K_OFF = 4;

  logic       clk = 1'b0, rst_n = 1'b0, usb_dp = 1'b0, usb_dn = 1'b1, rx_enable = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_eop, rx_error;

  usb_ls_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) dut (
    .clk(clk), .rst_n(rst_n), .usb_dp(usb_dp), .usb_dn(usb_dn), .rx_enable(rx_enable),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active),
    .rx_eop(rx_eop), .rx_error(rx_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fails = 0;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cumulative monitor; the stimulus side only reads it and works with deltas.
  logic [7:0] got_q[$];
  int eop_cnt = 0, err_cnt = 0, clash_cnt = 0, rst_strobe_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_data);
    if (rx_eop) eop_cnt++;
    if (rx_error) err_cnt++;
    if (rx_eop && rx_error) clash_cnt++;
    if (!rst_n && (rx_valid || rx_eop || rx_error || rx_active)) rst_strobe_cnt++;
  end

  logic [1:0] wire_q[$];
  int         byte_end_idx[$];
  logic [1:0] enc_last;
  int         enc_ones;
  logic       se0_hi;
  logic [7:0] pkt_bytes[4];
  logic [7:0] exp_q[$];
  int         exp_eop, exp_err;
  int         base_got, base_eop, base_err, base_clash;

  task automatic enc_raw(input logic b);
    if (!b) enc_last = (enc_last == W_J) ? W_K : W_J;
    wire_q.push_back(enc_last);
  endtask

  task automatic enc_data(input logic b);
    enc_raw(b);
    enc_ones = b ? enc_ones + 1 : 0;
    if (enc_ones == 6) begin
      enc_raw(1'b0);
      enc_ones = 0;
    end
  endtask

  task automatic enc_start();
    wire_q.delete();
    byte_end_idx.delete();
    enc_last = W_J;
    enc_ones = 0;
    for (int i = 0; i < 7; i++) enc_raw(1'b0);
    enc_raw(1'b1);
  endtask

  task automatic enc_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) enc_data(b[i]);
    byte_end_idx.push_back(wire_q.size());
  endtask

  task automatic enc_eop();
    wire_q.push_back(W_SE0);
    wire_q.push_back(W_SE0);
    for (int i = 0; i < 3; i++) wire_q.push_back(W_J);
  endtask

  task automatic drive_bit(input logic [1:0] s);
    case (s)
      W_J:     begin usb_dp = 1'b0;   usb_dn = 1'b1;   end
      W_K:     begin usb_dp = 1'b1;   usb_dn = 1'b0;   end
      default: begin usb_dp = se0_hi; usb_dn = se0_hi; end
    endcase
    repeat (CLKS_PER_BIT + $urandom_range(0, 1)) @(posedge clk);
    #1;
  endtask

  task automatic send(input int abort_idx);
    for (int i = 0; i < wire_q.size(); i++) begin
      if (i == abort_idx) rx_enable = 1'b0;
      drive_bit(wire_q[i]);
      if (i == 8 && rx_enable) check_eq("rx_active after SYNC", {31'd0, rx_active}, 1);
    end
  endtask

  // Expected outcome from the packet recipe alone.
  task automatic model(input int kind, input int nbytes);
    exp_q.delete();
    exp_eop = 0;
    exp_err = 0;
    if (kind != K_OFF) begin
      for (int i = 0; i < nbytes; i++) exp_q.push_back(pkt_bytes[i]);
      if (kind == K_GOOD) exp_eop = 1;
      else if (kind != K_ABORT) exp_err = 1;
      if (kind == K_ABORT) while (exp_q.size() > 1) void'(exp_q.pop_back());
`ifdef USB_RX_PID_CHECK_EN
      if (nbytes > 0 && pkt_bytes[0][7:4] != ~pkt_bytes[0][3:0]) begin
        exp_q.delete();
        exp_eop = 0;
        exp_err = 1;
      end
`endif
    end
  endtask

  task automatic mark();
    base_got   = got_q.size();
    base_eop   = eop_cnt;
    base_err   = err_cnt;
    base_clash = clash_cnt;
  endtask

  task automatic check_packet(input string name);
    int n;
    n = got_q.size() - base_got;
    check_eq({name, " byte count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check_eq({name, " rx_data"}, {24'd0, got_q[base_got + i]}, {24'd0, exp_q[i]});
    check_eq({name, " rx_eop count"}, eop_cnt - base_eop, exp_eop);
    check_eq({name, " rx_error count"}, err_cnt - base_err, exp_err);
    check_eq({name, " eop+error same cycle"}, clash_cnt - base_clash, 0);
    check_eq({name, " rx_active at idle"}, {31'd0, rx_active}, 0);
  endtask

  task automatic run_pkt(input string name, input int kind, input int nbytes, input int nextra);
    enc_start();
    for (int i = 0; i < nbytes; i++) enc_byte(pkt_bytes[i]);
    if (kind == K_ALIGN) for (int i = 0; i < nextra; i++) enc_data(1'($urandom_range(0, 1)));
    if (kind == K_STUFF) for (int i = 0; i < 7; i++) enc_raw(1'b1);
    enc_eop();
    se0_hi = 1'($urandom_range(0, 1));
    model(kind, nbytes);
    mark();
    rx_enable = 1'b1;
    if (kind == K_OFF)        send(0);
    else if (kind == K_ABORT) send(byte_end_idx[0]);
    else                      send(-1);
    check_packet(name);
    rx_enable = 1'b1;
    drive_bit(W_J);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check_eq("reset rx_data", {24'd0, rx_data}, 0);
    check_eq("reset rx_valid", {31'd0, rx_valid}, 0);
    check_eq("reset rx_active", {31'd0, rx_active}, 0);
    check_eq("reset rx_eop", {31'd0, rx_eop}, 0);
    check_eq("reset rx_error", {31'd0, rx_error}, 0);
    rst_n = 1'b1;
    rx_enable = 1'b1;
    repeat (3) drive_bit(W_J);

    pkt_bytes[0] = 8'hC3;                       run_pkt("data0", K_GOOD, 1, 0);
    pkt_bytes[0] = 8'h69; pkt_bytes[1] = 8'hFF; run_pkt("stuffed ff", K_GOOD, 2, 0);
    run_pkt("seven ones", K_STUFF, 0, 0);
    pkt_bytes[0] = 8'h2D;                       run_pkt("alignment", K_ALIGN, 1, 3);
    pkt_bytes[0] = 8'h2C;                       run_pkt("pid 2c", K_GOOD, 1, 0);
    pkt_bytes[0] = 8'hC3;                       run_pkt("disabled", K_OFF, 1, 0);
    pkt_bytes[0] = 8'hC3; pkt_bytes[1] = 8'h55; pkt_bytes[2] = 8'hAA;
    run_pkt("abort", K_ABORT, 3, 0);

    // Reset in the middle of a byte, then a fresh packet.
    enc_start();
    enc_byte(8'h3C);
    mark();
    begin
      int rst_base;
      rst_base = rst_strobe_cnt;
      for (int i = 0; i < 12; i++) drive_bit(wire_q[i]);
      rst_n = 1'b0;
      #1;
      check_eq("mid reset rx_data", {24'd0, rx_data}, 0);
      check_eq("mid reset rx_active", {31'd0, rx_active}, 0);
      for (int i = 12; i < 16; i++) drive_bit(wire_q[i]);
      repeat (3) drive_bit(W_J);
      check_eq("strobes during reset", rst_strobe_cnt - rst_base, 0);
      rst_n = 1'b1;
      repeat (2) drive_bit(W_J);
      check_eq("partial byte discarded", got_q.size() - base_got, 0);
    end
    pkt_bytes[0] = 8'hA5; run_pkt("after reset", K_GOOD, 1, 0);

    for (int t = 0; t < 20; t++) begin
      int kind, nb;
      kind = $urandom_range(0, 2);
      nb = (kind == K_STUFF) ? $urandom_range(0, 3) : $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) pkt_bytes[i] = 8'($urandom);
      run_pkt($sformatf("rand%0d", t), kind, nb, $urandom_range(1, 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/usb_ls_rx.md
USB_LS_RX -- requirements
Module: usb_ls_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 18, meaning clk cycles per low-speed bit (27 MHz / 1.5 Mb/s).
REQ-002 SHALL have port clk  input  1  system clock, 27 MHz.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port usb_dp  input  1  raw D+ line, asynchronous to clk.
REQ-005 SHALL have port usb_dn  input  1  raw D- line, asynchronous to clk.
REQ-006 SHALL have port rx_enable  input  1  receiver enable; low forces IDLE.
REQ-007 SHALL have port rx_data  output  8  received byte, LSB first on wire.
REQ-008 SHALL have port rx_valid  output  1  one-cycle strobe, rx_data valid.
REQ-009 SHALL have port rx_active  output  1  high from SYNC complete until EOP/error/abort.
REQ-010 SHALL have port rx_eop  output  1  one-cycle strobe on valid end of packet.
REQ-011 SHALL have port rx_error  output  1  one-cycle strobe on stuff, alignment or PID error.

Function
REQ-012 SHALL pass usb_dp and usb_dn each through a 2-flop synchronizer; all logic uses synchronized values.
REQ-013 SHALL decode line state, low-speed polarity: J = dn1/dp0, K = dp1/dn0, SE0 = both 0; both 1 treated as SE0.
REQ-014 SHALL reload the bit-phase counter to CLKS_PER_BIT/2 on every J/K transition and sample once per CLKS_PER_BIT thereafter (mid-bit).
REQ-015 SHALL NRZI-decode each sample: same state as previous sample = 1, change = 0; previous state resets to J.
REQ-016 SHALL implement states IDLE, SYNC, DATA, EOP.
REQ-017 IDLE -> SYNC on first K sample while rx_enable is high.
REQ-018 SYNC -> DATA after at least 5 consecutive decoded 0s followed by a decoded 1; rx_active rises the cycle after the 1 is sampled.
REQ-019 SYNC -> IDLE without rx_error on SE0 or on a decoded 1 after fewer than 5 zeros.
REQ-020 DATA: shift decoded bits in LSB first; after the 8th non-stuff bit, rx_data updates and rx_valid pulses one cycle later; bit counter wraps to 0.
REQ-021 Bit unstuffing: after six consecutive decoded 1s the next bit SHALL be dropped if 0; if 1, rx_error pulses, rx_active drops, state -> EOP.
REQ-022 The ones counter SHALL include bits across byte boundaries and reset on any decoded 0.
REQ-023 DATA -> EOP on SE0 sample; if bit counter is 0 the packet is good, otherwise rx_error pulses (alignment error).
REQ-024 EOP -> IDLE on first J sample after at least one SE0 sample; rx_eop pulses that cycle only for a good packet; rx_active drops the same cycle.
REQ-025 rx_eop and rx_error SHALL never pulse in the same cycle; at most one of them per packet.
REQ-026 rx_enable low in any state SHALL return to IDLE next cycle, drop rx_active, and suppress rx_valid/rx_eop/rx_error.
REQ-027 SE0 in IDLE SHALL be ignored (bus reset detection is out of scope).

Reset
REQ-028 On rst_n low: state IDLE, synchronizers to J (dp0, dn1), rx_data 8'h00, rx_valid/rx_active/rx_eop/rx_error 0, all counters 0.
REQ-029 Reset asserted mid-packet SHALL discard the partial byte; after release the block waits for a new SYNC.

Configuration
REQ-030 Macro USB_RX_PID_CHECK_EN: when defined, the first byte of each packet SHALL be checked rx_data[7:4] == ~rx_data[3:0]; on mismatch rx_valid is suppressed, rx_error pulses, state -> EOP.
REQ-031 Without USB_RX_PID_CHECK_EN, the first byte is delivered like any other byte with no check.

Verification
REQ-032 SYNC + byte 8'hC3 (DATA0 PID) + SE0 2 bits + J -> rx_valid once with rx_data 8'hC3, then rx_eop once, rx_error never.
REQ-033 SYNC + PID 8'h69 + byte 8'hFF -> one stuffed 0 inserted on wire is removed; rx_data sequence 8'h69, 8'hFF; rx_eop.
REQ-034 SYNC + seven consecutive decoded 1s -> rx_error pulse, rx_active low, no rx_eop.
REQ-035 SYNC + PID 8'h2D + 3 extra bits + SE0 -> rx_valid for 8'h2D, then rx_error (alignment), no rx_eop.
REQ-036 With USB_RX_PID_CHECK_EN: SYNC + 8'h2C -> no rx_valid, rx_error pulse; without macro -> rx_valid with 8'h2C.
REQ-037 rst_n low mid-byte, then full packet 8'hA5 -> no output strobes during reset; second packet yields only the PID 8'hA5 and rx_eop.
